sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative integer square-root unit (start/busy/valid/rad/root/rem interface, ITER = WIDTH/2 busy cycles) among N_REQ requesters.
- Accepts one radicand at a time via valid/ready, pulses the unit's start, and detects completion.
- Returns root/remainder to the owning requester via a per-requester response handshake.
- Used by the Pythagorean datapath so multiple hypotenuse lanes reuse a single root engine.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 16, radicand/root/remainder width (even); must match the sqrt unit.
- TIMEOUT, 64, max RUN cycles before the job is aborted with an error (> WIDTH/2 + 2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_rad  input  N_REQ*WIDTH  radicands; requester k at bits [k*WIDTH +: WIDTH].
- rsp_valid  output  N_REQ  response valid; at most one bit high, the owner's.
- rsp_ready  input  N_REQ  per-requester response accept.
- rsp_root  output  WIDTH  root for the current response.
- rsp_rem  output  WIDTH  remainder for the current response.
- rsp_err  output  1  current response aborted by timeout; root/rem are 0.
- sq_start  output  1  start pulse to the sqrt unit.
- sq_rad  output  WIDTH  radicand to the sqrt unit.
- sq_busy  input  1  sqrt unit busy.
- sq_valid  input  1  sqrt unit result valid.
- sq_root  input  WIDTH  sqrt unit root.
- sq_rem  input  WIDTH  sqrt unit remainder.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, last_grant=N_REQ-1.
  - All outputs 0: req_ready, rsp_valid, rsp_root, rsp_rem, rsp_err, sq_start, sq_rad.
  - Watchdog counter 0.
  - The sqrt unit has no reset. sq_busy/sq_valid are ignored outside RUN.
- FSM states: IDLE, ISSUE, RUN, RESP.
- IDLE:
  - Grant g is the first index with req_valid high, searching (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[g]=1, combinational from req_valid, only in IDLE.
  - On handshake: latch req_rad[g] into sq_rad and g into owner; last_grant<=g; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: one cycle. sq_start=1 (registered output, high exactly this cycle); sq_rad stable. Next state RUN; watchdog cleared.
- RUN:
  - Watchdog increments each cycle.
  - Completion is sq_busy==0 && sq_valid==1, sampled from the second RUN cycle onward. The first RUN cycle is ignored because the unit's busy rises then.
  - On completion: capture sq_root into rsp_root, sq_rem into rsp_rem, rsp_err<=0; go to RESP.
  - If the watchdog reaches TIMEOUT first: rsp_root<=0, rsp_rem<=0, rsp_err<=1; go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_root/rsp_rem/rsp_err held stable until rsp_ready[owner]=1.
  - On handshake: rsp_valid<=0; go to IDLE. rsp_ready of non-owners is ignored.
- Latency with WIDTH=16 (ITER=8): request handshake cycle T0, ISSUE T1, unit busy T2..T9, completion seen at T10, rsp_valid high from T11 (ITER+3).
  - Next request accepted the cycle after the response handshake: one job in flight, no overlap.
- Fairness: the requester just served has lowest priority at the next arbitration. Any continuously-requesting requester is served within N_REQ jobs.
- Requester rules:
  - req_rad must be stable while req_valid is high.
  - A requester may deassert req_valid before ready; nothing is latched.
  - Requests arriving during ISSUE/RUN/RESP are held off (ready=0).
- Reset mid-operation: FSM returns to IDLE immediately and the in-flight job is dropped with no response.
  - An orphaned sqrt computation is overridden by the next sq_start, which takes priority in the unit.
- Widths: rad/root/rem are unsigned WIDTH. Watchdog is $clog2(TIMEOUT+1) bits and saturates. Owner/last_grant are $clog2(N_REQ) bits.

Test Plan:
- Single: req_valid[0]=1, rad=144 -> req_ready[0] at T0, sq_start only at T1, rsp_valid[0] at T11 with root=12, rem=0, err=0.
- Boundary values: rad=0 -> root 0, rem 0; rad=65535 -> root 255, rem 510; rad=1 -> root 1, rem 0.
- Contention: all four request at once (rads 4, 9, 16, 25) -> grants 0, 1, 2, 3 in order, roots 2, 3, 4, 5 on matching rsp_valid bits.
  - Then req 0 and 2 re-request after grant 1 -> order 2, then 0.
- Backpressure: rsp_ready[1]=0 for 5 cycles after rsp_valid[1] -> outputs held stable, no new req_ready; handshake on cycle 6, IDLE next cycle.
- Reset: assert rst_n=0 in the third RUN cycle -> all outputs 0 immediately.
  - After release, a new rad=49 yields root 7 with correct timing.
- Timeout: sqrt stub holding sq_busy=1 -> rsp_err=1, root=rem=0 after 64 RUN cycles; arbiter then serves the next requester.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end that shares one iterative square-root unit
// among N_REQ requesters and returns each result to its owner; a watchdog aborts hung jobs.
module sqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_rad,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_root,
  output logic [WIDTH-1:0]       rsp_rem,
  output logic                   rsp_err,
  output logic                   sq_start,
  output logic [WIDTH-1:0]       sq_rad,
  input  logic                   sq_busy,
  input  logic                   sq_valid,
  input  logic [WIDTH-1:0]       sq_root,
  input  logic [WIDTH-1:0]       sq_rem
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] grant_rad;
  logic [N_REQ-1:0] owner_oh;
  logic [WD_W-1:0]  watchdog;
  logic             done;
  logic             expired;

  // Search starts just past the last winner so the requester just served ranks lowest.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_grant) + i) % N_REQ;
      if (!grant_any && req_valid[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_rad = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) grant_rad = req_rad[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  // The first RUN cycle is skipped because the unit only raises busy then.
  assign done    = (watchdog != '0) && !sq_busy && sq_valid;
  assign expired = (watchdog == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      owner      <= '0;
      watchdog   <= '0;
      sq_start   <= 1'b0;
      sq_rad     <= '0;
      rsp_valid  <= '0;
      rsp_root   <= '0;
      rsp_rem    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            sq_rad     <= grant_rad;
            owner      <= grant_idx;
            last_grant <= grant_idx;
            sq_start   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          sq_start <= 1'b0;
          watchdog <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (watchdog != WD_MAX) watchdog <= watchdog + 1'b1;
          if (done) begin
            rsp_root  <= sq_root;
            rsp_rem   <= sq_rem;
            rsp_err   <= 1'b0;
            rsp_valid <= owner_oh;
            state     <= RESP;
          end else if (expired) begin
            rsp_root  <= '0;
            rsp_rem   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner_oh;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: drives sqrt_arbiter with a behavioural square-root unit and checks
// grants, results and timing against a round-robin reference model.
module tb_sqrt_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int TO   = 64;
  localparam int ITER = W / 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_rad;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_root;
  logic [W-1:0]   rsp_rem;
  logic           rsp_err;
  logic           sq_start;
  logic [W-1:0]   sq_rad;
  logic           sq_busy  = 1'b0;
  logic           sq_valid = 1'b0;
  logic [W-1:0]   sq_root  = '0;
  logic [W-1:0]   sq_rem   = '0;

  int checks = 0;
  int passed = 0;
  int model_last = N - 1;
  bit stub_hang = 1'b0;
  int stub_cnt = 0;

  sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rad(req_rad),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
    .sq_start(sq_start), .sq_rad(sq_rad),
    .sq_busy(sq_busy), .sq_valid(sq_valid), .sq_root(sq_root), .sq_rem(sq_rem)
  );

  always #5 clk = ~clk;

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Iterative root engine: busy for ITER cycles after start, no reset, can be told to hang.
  always @(posedge clk) begin
    int unsigned r;
    r = isqrt(int'(sq_rad));
    if (sq_start) begin
      sq_busy  <= 1'b1;
      sq_valid <= 1'b0;
      stub_cnt <= ITER;
      sq_root  <= W'(r);
      sq_rem   <= W'(int'(sq_rad) - r * r);
    end else if (sq_busy && !stub_hang) begin
      if (stub_cnt == 1) begin
        sq_busy  <= 1'b0;
        sq_valid <= 1'b1;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  function automatic int onehot_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -2;
  endfunction

  function automatic int model_pick(input logic [N-1:0] pend);
    for (int i = 1; i <= N; i++) begin
      if (pend[(model_last + i) % N]) return (model_last + i) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_last = N - 1;
  endtask

  task automatic set_rad(input int k, input int unsigned v);
    req_rad[k*W +: W] = W'(v);
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != '0) begin
        g = onehot_idx(req_ready);
        return;
      end
      tick();
    end
  endtask

  // Called in the cycle after the request handshake; counts cycles until rsp_valid.
  task automatic wait_rsp(output int owner, output logic [W-1:0] root, output logic [W-1:0] rem,
                          output logic err, output int lat, output int starts,
                          output int start_cyc, output bit ready_seen);
    owner = -1; root = '0; rem = '0; err = 1'b0;
    starts = 0; start_cyc = -1; ready_seen = 1'b0; lat = 0;
    for (int c = 1; c <= 200; c++) begin
      lat = c;
      if (sq_start) begin
        starts++;
        start_cyc = c;
      end
      if (req_ready != '0) ready_seen = 1'b1;
      if (rsp_valid != '0) begin
        owner = onehot_idx(rsp_valid);
        root  = rsp_root;
        rem   = rsp_rem;
        err   = rsp_err;
        return;
      end
      tick();
    end
  endtask

  task automatic finish_rsp(input int k);
    if (k >= 0) rsp_ready[k] = 1'b1;
    else rsp_ready = '1;
    tick();
    rsp_ready = '0;
  endtask

  task automatic issue_one(input int k, input int unsigned v, output int g);
    set_rad(k, v);
    req_valid[k] = 1'b1;
    wait_grant(g);
    tick();
    req_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_rad = '0;
    #1;
    rst_n = 1'b0;
    #3;
    checks++; if (req_ready !== '0) $display("[TB] FAIL reset_req_ready: got %b, expected 0", req_ready); else passed++;
    checks++; if (rsp_valid !== '0) $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); else passed++;
    checks++; if (rsp_root !== '0) $display("[TB] FAIL reset_rsp_root: got %0d, expected 0", rsp_root); else passed++;
    checks++; if (rsp_rem !== '0) $display("[TB] FAIL reset_rsp_rem: got %0d, expected 0", rsp_rem); else passed++;
    checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err: got %b, expected 0", rsp_err); else passed++;
    checks++; if (sq_start !== 1'b0) $display("[TB] FAIL reset_sq_start: got %b, expected 0", sq_start); else passed++;
    checks++; if (sq_rad !== '0) $display("[TB] FAIL reset_sq_rad: got %0d, expected 0", sq_rad); else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_last = N - 1;
  endtask

  task automatic test_single();
    int g, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    issue_one(0, 144, g);
    model_last = 0;
    checks++; if (g !== 0) $display("[TB] FAIL single_grant: got %0d, expected 0", g); else passed++;
    wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
    checks++; if (starts !== 1) $display("[TB] FAIL single_start_count: got %0d, expected 1", starts); else passed++;
    checks++; if (start_cyc !== 1) $display("[TB] FAIL single_start_cycle: got %0d, expected 1", start_cyc); else passed++;
    checks++; if (lat !== ITER + 3) $display("[TB] FAIL single_latency: got %0d, expected %0d", lat, ITER + 3); else passed++;
    checks++; if (owner !== 0) $display("[TB] FAIL single_owner: got %0d, expected 0", owner); else passed++;
    checks++; if (root !== 16'd12) $display("[TB] FAIL single_root: got %0d, expected 12", root); else passed++;
    checks++; if (rem !== 16'd0) $display("[TB] FAIL single_rem: got %0d, expected 0", rem); else passed++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL single_err: got %b, expected 0", err); else passed++;
    checks++; if (rdy !== 1'b0) $display("[TB] FAIL single_ready_held_off: got %b, expected 0", rdy); else passed++;
    finish_rsp(owner);
    checks++; if (rsp_valid !== '0) $display("[TB] FAIL single_rsp_drop: got %b, expected 0", rsp_valid); else passed++;
  endtask

  task automatic test_boundary();
    int unsigned rads[3]  = '{0, 65535, 1};
    int unsigned roots[3] = '{0, 255, 1};
    int unsigned rems[3]  = '{0, 510, 0};
    int g, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    for (int i = 0; i < 3; i++) begin
      issue_one(i + 1, rads[i], g);
      model_last = i + 1;
      checks++; if (g !== i + 1) $display("[TB] FAIL boundary_grant[%0d]: got %0d, expected %0d", i, g, i + 1); else passed++;
      wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
      checks++; if (owner !== i + 1) $display("[TB] FAIL boundary_owner[%0d]: got %0d, expected %0d", i, owner, i + 1); else passed++;
      checks++; if (root !== W'(roots[i])) $display("[TB] FAIL boundary_root[%0d]: got %0d, expected %0d", i, root, roots[i]); else passed++;
      checks++; if (rem !== W'(rems[i])) $display("[TB] FAIL boundary_rem[%0d]: got %0d, expected %0d", i, rem, rems[i]); else passed++;
      checks++; if (err !== 1'b0) $display("[TB] FAIL boundary_err[%0d]: got %b, expected 0", i, err); else passed++;
      checks++; if (lat !== ITER + 3) $display("[TB] FAIL boundary_latency[%0d]: got %0d, expected %0d", i, lat, ITER + 3); else passed++;
      finish_rsp(owner);
    end
  endtask

  task automatic test_contention();
    int exp_order[4] = '{1, 2, 0, -1};
    int exp_root[3]  = '{6, 8, 7};
    int g, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    apply_reset();
    for (int k = 0; k < N; k++) set_rad(k, (k + 2) * (k + 2));
    req_valid = '1;
    for (int j = 0; j < N; j++) begin
      wait_grant(g);
      checks++; if (g !== j) $display("[TB] FAIL contention_grant[%0d]: got %0d, expected %0d", j, g, j); else passed++;
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
      wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
      checks++; if (owner !== j) $display("[TB] FAIL contention_owner[%0d]: got %0d, expected %0d", j, owner, j); else passed++;
      checks++; if (root !== W'(j + 2)) $display("[TB] FAIL contention_root[%0d]: got %0d, expected %0d", j, root, j + 2); else passed++;
      checks++; if (rem !== '0) $display("[TB] FAIL contention_rem[%0d]: got %0d, expected 0", j, rem); else passed++;
      finish_rsp(owner);
    end
    req_valid = '0;
    // Requester 1 alone, then 0 and 2 together: 2 follows 1 in the rotation.
    set_rad(1, 36);
    set_rad(2, 64);
    set_rad(0, 49);
    for (int j = 0; j < 3; j++) begin
      if (j == 0) req_valid = 4'b0010;
      if (j == 1) req_valid = 4'b0101;
      wait_grant(g);
      checks++; if (g !== exp_order[j]) $display("[TB] FAIL rotate_grant[%0d]: got %0d, expected %0d", j, g, exp_order[j]); else passed++;
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
      wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
      checks++; if (root !== W'(exp_root[j])) $display("[TB] FAIL rotate_root[%0d]: got %0d, expected %0d", j, root, exp_root[j]); else passed++;
      finish_rsp(owner);
    end
    req_valid = '0;
    model_last = 0;
  endtask

  task automatic test_backpressure();
    int g, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    logic [3*N+2*W:0] held;
    issue_one(1, 100, g);
    model_last = 1;
    checks++; if (g !== 1) $display("[TB] FAIL bp_grant: got %0d, expected 1", g); else passed++;
    set_rad(0, 121);
    req_valid[0] = 1'b1;
    wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
    checks++; if (rdy !== 1'b0) $display("[TB] FAIL bp_ready_during_job: got %b, expected 0", rdy); else passed++;
    checks++; if (owner !== 1) $display("[TB] FAIL bp_owner: got %0d, expected 1", owner); else passed++;
    rsp_ready = 4'b1101;
    for (int c = 2; c <= 6; c++) begin
      tick();
      #1;
      held = {rsp_valid, rsp_root, rsp_rem, rsp_err, req_ready, 4'b0000};
      checks++;
      if (held !== {4'b0010, 16'd10, 16'd0, 1'b0, 4'b0000, 4'b0000})
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b root=%0d rem=%0d err=%b ready=%b, expected valid=0010 root=10 rem=0 err=0 ready=0000",
                 c, rsp_valid, rsp_root, rsp_rem, rsp_err, req_ready);
      else passed++;
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    #1;
    checks++; if (rsp_valid !== '0) $display("[TB] FAIL bp_rsp_drop: got %b, expected 0000", rsp_valid); else passed++;
    checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL bp_idle_next: got %b, expected 0001", req_ready); else passed++;
    tick();
    req_valid[0] = 1'b0;
    model_last = 0;
    wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
    checks++; if (owner !== 0) $display("[TB] FAIL bp_next_owner: got %0d, expected 0", owner); else passed++;
    checks++; if (root !== 16'd11) $display("[TB] FAIL bp_next_root: got %0d, expected 11", root); else passed++;
    finish_rsp(owner);
  endtask

  task automatic test_reset_mid();
    int g, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    issue_one(2, 200, g);
    tick();
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, req_ready, sq_start, rsp_err} !== '0 || sq_rad !== '0 || rsp_root !== '0 || rsp_rem !== '0)
      $display("[TB] FAIL midreset_outputs: got valid=%b ready=%b start=%b err=%b sq_rad=%0d root=%0d rem=%0d, expected all 0",
               rsp_valid, req_ready, sq_start, rsp_err, sq_rad, rsp_root, rsp_rem);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    model_last = N - 1;
    issue_one(2, 49, g);
    model_last = 2;
    checks++; if (g !== 2) $display("[TB] FAIL midreset_grant: got %0d, expected 2", g); else passed++;
    wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
    checks++; if (lat !== ITER + 3) $display("[TB] FAIL midreset_latency: got %0d, expected %0d", lat, ITER + 3); else passed++;
    checks++; if (owner !== 2) $display("[TB] FAIL midreset_owner: got %0d, expected 2", owner); else passed++;
    checks++; if (root !== 16'd7 || rem !== 16'd0) $display("[TB] FAIL midreset_result: got root=%0d rem=%0d, expected root=7 rem=0", root, rem); else passed++;
    finish_rsp(owner);
  endtask

  task automatic test_timeout();
    int g, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    stub_hang = 1'b1;
    set_rad(3, 81);
    set_rad(0, 169);
    req_valid = 4'b1001;
    wait_grant(g);
    checks++; if (g !== 3) $display("[TB] FAIL timeout_grant: got %0d, expected 3", g); else passed++;
    tick();
    req_valid[3] = 1'b0;
    wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
    checks++; if (lat !== TO + 2) $display("[TB] FAIL timeout_latency: got %0d, expected %0d", lat, TO + 2); else passed++;
    checks++; if (owner !== 3) $display("[TB] FAIL timeout_owner: got %0d, expected 3", owner); else passed++;
    checks++; if (err !== 1'b1) $display("[TB] FAIL timeout_err: got %b, expected 1", err); else passed++;
    checks++; if (root !== '0 || rem !== '0) $display("[TB] FAIL timeout_result: got root=%0d rem=%0d, expected 0 0", root, rem); else passed++;
    stub_hang = 1'b0;
    finish_rsp(owner);
    wait_grant(g);
    checks++; if (g !== 0) $display("[TB] FAIL timeout_next_grant: got %0d, expected 0", g); else passed++;
    tick();
    req_valid = '0;
    wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
    checks++; if (root !== 16'd13 || err !== 1'b0) $display("[TB] FAIL timeout_next_result: got root=%0d err=%b, expected root=13 err=0", root, err); else passed++;
    finish_rsp(owner);
    model_last = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    int unsigned rads[N];
    int unsigned er, em;
    int g, e, k, owner, lat, starts, start_cyc;
    logic [W-1:0] root, rem;
    logic err;
    bit rdy;
    pend = '0;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          rads[i] = $urandom_range(0, 65535);
          set_rad(i, rads[i]);
        end
      end
      if (pend == '0) begin
        k = $urandom_range(0, N - 1);
        pend[k] = 1'b1;
        rads[k] = $urandom_range(0, 65535);
        set_rad(k, rads[k]);
      end
      // A withdrawn request must leave no trace.
      if ($countones(pend) > 1 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N - 1);
        pend[k] = 1'b0;
      end
      req_valid = pend;
      e = model_pick(pend);
      wait_grant(g);
      checks++; if (g !== e) $display("[TB] FAIL random_grant[%0d]: got %0d, expected %0d", j, g, e); else passed++;
      tick();
      if (g >= 0) pend[g] = 1'b0;
      req_valid = pend;
      model_last = e;
      er = isqrt(rads[e]);
      em = rads[e] - er * er;
      wait_rsp(owner, root, rem, err, lat, starts, start_cyc, rdy);
      checks++; if (owner !== e) $display("[TB] FAIL random_owner[%0d]: got %0d, expected %0d", j, owner, e); else passed++;
      checks++;
      if (root !== W'(er) || rem !== W'(em) || err !== 1'b0)
        $display("[TB] FAIL random_result[%0d]: got root=%0d rem=%0d err=%b, expected root=%0d rem=%0d err=0", j, root, rem, err, er, em);
      else passed++;
      checks++; if (lat !== ITER + 3) $display("[TB] FAIL random_latency[%0d]: got %0d, expected %0d", j, lat, ITER + 3); else passed++;
      checks++; if (rdy !== 1'b0) $display("[TB] FAIL random_held_off[%0d]: got %b, expected 0", j, rdy); else passed++;
      repeat ($urandom_range(0, 3)) tick();
      finish_rsp(owner);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
